multi_alarm_clock: RTL and testbench

//  Parametrised successor of the single-alarm clock datapath. It keeps 24h BCD time with seconds,

---
 rtl/alarm_clock_pkg.sv | 53 +++++
 rtl/multi_alarm_clock_counter.sv | 77 +++++++
 rtl/multi_alarm_clock.sv | 162 ++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock.
// Time values are packed BCD bytes {tens,units}.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
  } bcd_time_t;

  function automatic logic bcd_valid_time(
    input logic [7:0] hr,
    input logic [7:0] min
  );
    bcd_t hu;
    bcd_t mu;
    hu = hr[3:0];
    mu = min[3:0];
    return (hu <= 4'd9) && (mu <= 4'd9) &&
           (hr <= 8'h23) && (min <= 8'h59);
  endfunction

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] to_12h(
    input logic [7:0] hr
  );
    logic [6:0] b;
    b = 7'(hr[7:4]) * 7'd10 + 7'(hr[3:0]);
    if (hr == 8'h00)
      return 8'h12;
    if (hr <= 8'h12)
      return hr;
    b = b - 7'd12;
    if (b >= 7'd10)
      return {4'd1, 4'(b - 7'd10)};
    return {4'd0, 4'(b)};
  endfunction

endpackage

// File: rtl/multi_alarm_clock_counter.sv
// Prescaler and sec/min/hr BCD chain with time load.
// min_tick and next-time outputs are combinational for same-edge matching.
module bcd_time_counter
  import alarm_clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fastwatch_i,
  input  logic       load_i,
  input  logic [7:0] ld_hr_i,
  input  logic [7:0] ld_min_i,
  output logic [7:0] hr_o,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] nxt_hr_o,
  output logic [7:0] nxt_min_o,
  output logic       min_tick_o
);

  localparam int PW = $clog2(CLK_PER_SEC);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic          tick;
  logic          mtick;

  assign tick = (pre_q == PW'(CLK_PER_SEC - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    mtick = 1'b0;
    // A load drops any tick landing in the same cycle
    if (load_i) begin
      pre_d = '0;
      sec_d = 8'h00;
      min_d = ld_min_i;
      hr_d  = ld_hr_i;
    end else if (tick) begin
      mtick = fastwatch_i || (sec_q == 8'h59);
      sec_d = mtick ? 8'h00 : bcd_inc(sec_q);
      if (mtick) begin
        min_d = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
        if (min_q == 8'h59)
          hr_d = (hr_q == 8'h23) ? 8'h00 : bcd_inc(hr_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      hr_q  <= '0;
      min_q <= '0;
      sec_q <= '0;
    end else begin
      pre_q <= pre_d;
      hr_q  <= hr_d;
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  assign hr_o       = hr_q;
  assign min_o      = min_q;
  assign sec_o      = sec_q;
  assign nxt_hr_o   = hr_d;
  assign nxt_min_o  = min_d;
  assign min_tick_o = mtick;

endmodule

// File: rtl/multi_alarm_clock.sv
// Multi-alarm clock: alarm slots, priority match and
// ring/snooze/timeout FSM around the BCD time counter.
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter  int NUM_ALARMS  = 4,
  parameter  int CLK_PER_SEC = 256,
  parameter  int SNOOZE_MIN  = 5,
  parameter  int RING_MIN    = 2,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fastwatch,
  input  logic          set_time,
  input  logic [7:0]    new_hr,
  input  logic [7:0]    new_min,
  input  logic          alarm_wr,
  input  logic [AW-1:0] alarm_sel,
  input  logic          alarm_en_in,
  input  logic          snooze,
  input  logic          stop,
  input  logic          mode_12h,
  output logic [7:0]    disp_hr,
  output logic [7:0]    disp_min,
  output logic [7:0]    disp_sec,
  output logic          pm,
  output logic          alarm_sound,
  output logic [AW-1:0] alarm_id,
  output logic          set_err
);

  logic       vt, sel_ok, ld, wr_ok, err_d, err_q;
  logic [7:0] hr, nxt_hr, nxt_min;
  logic       min_tick;

  assign vt     = bcd_valid_time(new_hr, new_min);
  assign sel_ok = int'(alarm_sel) < NUM_ALARMS;
  assign ld     = set_time & vt;
  assign wr_ok  = alarm_wr & vt & sel_ok;
  assign err_d  = (set_time & ~vt) |
                  (alarm_wr & ~(vt & sel_ok));

  bcd_time_counter #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_cnt (
    .clk        (clock),
    .rst_n      (reset),
    .fastwatch_i(fastwatch),
    .load_i     (ld),
    .ld_hr_i    (new_hr),
    .ld_min_i   (new_min),
    .hr_o       (hr),
    .min_o      (disp_min),
    .sec_o      (disp_sec),
    .nxt_hr_o   (nxt_hr),
    .nxt_min_o  (nxt_min),
    .min_tick_o (min_tick)
  );

  bcd_time_t             alm_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++)
        alm_q[i] <= '0;
      en_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (wr_ok) begin
        alm_q[alarm_sel] <= '{hr: new_hr, min: new_min};
        en_q[alarm_sel]  <= alarm_en_in;
      end
    end
  end

  bcd_time_t     nxt;
  logic          hit;
  logic [AW-1:0] hit_id;

  assign nxt = '{hr: nxt_hr, min: nxt_min};

  // Scan downwards so the lowest matching slot is kept
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en_q[i] && (alm_q[i] == nxt)) begin
        hit    = 1'b1;
        hit_id = AW'(i);
      end
    end
  end

  state_e        state_q, state_d;
  logic [3:0]    ring_q, ring_d;
  logic [3:0]    snz_q, snz_d;
  logic [AW-1:0] id_q, id_d;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (min_tick && hit) begin
          state_d = RING;
          id_d    = hit_id;
          ring_d  = 4'(RING_MIN);
        end
      end
      RING: begin
        if (stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNOOZE;
          snz_d   = 4'(SNOOZE_MIN);
        end else if (min_tick) begin
          ring_d = ring_q - 4'd1;
          if (ring_q <= 4'd1)
            state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (min_tick) begin
          snz_d = snz_q - 4'd1;
          if (snz_q <= 4'd1) begin
            state_d = RING;
            ring_d  = 4'(RING_MIN);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      id_q    <= id_d;
    end
  end

  assign disp_hr     = mode_12h ? to_12h(hr) : hr;
  assign pm          = (hr >= 8'h12);
  assign alarm_sound = (state_q == RING);
  assign alarm_id    = id_q;
  assign set_err     = err_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with CLK_PER_SEC=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_multi_alarm_clock;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       fastwatch = 1'b0;
  logic       set_time = 1'b0;
  logic [7:0] new_hr = '0;
  logic [7:0] new_min = '0;
  logic       alarm_wr = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic       alarm_en_in = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       mode_12h = 1'b0;
  logic [7:0] disp_hr, disp_min, disp_sec;
  logic       pm, alarm_sound, set_err;
  logic [1:0] alarm_id;

  multi_alarm_clock #(
    .NUM_ALARMS (4),
    .CLK_PER_SEC(4),
    .SNOOZE_MIN (5),
    .RING_MIN   (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fastwatch  (fastwatch),
    .set_time   (set_time),
    .new_hr     (new_hr),
    .new_min    (new_min),
    .alarm_wr   (alarm_wr),
    .alarm_sel  (alarm_sel),
    .alarm_en_in(alarm_en_in),
    .snooze     (snooze),
    .stop       (stop),
    .mode_12h   (mode_12h),
    .disp_hr    (disp_hr),
    .disp_min   (disp_min),
    .disp_sec   (disp_sec),
    .pm         (pm),
    .alarm_sound(alarm_sound),
    .alarm_id   (alarm_id),
    .set_err    (set_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_t(input logic [7:0] h,
                       input logic [7:0] m);
    new_hr   = h;
    new_min  = m;
    set_time = 1'b1;
    @(negedge clock);
    set_time = 1'b0;
  endtask

  task automatic wr_alm(input logic [1:0] s,
                        input logic [7:0] h,
                        input logic [7:0] m,
                        input logic       en);
    alarm_sel   = s;
    new_hr      = h;
    new_min     = m;
    alarm_en_in = en;
    alarm_wr    = 1'b1;
    @(negedge clock);
    alarm_wr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] hr;
    logic [7:0] mn;
    logic       m12;
    logic [7:0] e_hr;
    logic [7:0] e_min;
    logic       e_pm;
    logic       e_err;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{8'h24, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[2]  = '{8'h00, 8'h00, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{8'h13, 8'h5A, 1'b1, 8'h12, 8'h00, 1'b0, 1'b1};
    vt[4]  = '{8'h12, 8'h30, 1'b1, 8'h12, 8'h30, 1'b1, 1'b0};
    vt[5]  = '{8'h0A, 8'h00, 1'b1, 8'h12, 8'h30, 1'b1, 1'b1};
    vt[6]  = '{8'h13, 8'h05, 1'b1, 8'h01, 8'h05, 1'b1, 1'b0};
    vt[7]  = '{8'h09, 8'h60, 1'b1, 8'h01, 8'h05, 1'b1, 1'b1};
    vt[8]  = '{8'h23, 8'h59, 1'b1, 8'h11, 8'h59, 1'b1, 1'b0};
    vt[9]  = '{8'h11, 8'h59, 1'b1, 8'h11, 8'h59, 1'b0, 1'b0};
    vt[10] = '{8'h19, 8'h45, 1'b0, 8'h19, 8'h45, 1'b1, 1'b0};
    vt[11] = '{8'h20, 8'h10, 1'b1, 8'h08, 8'h10, 1'b1, 1'b0};
    vt[12] = '{8'h09, 8'h07, 1'b1, 8'h09, 8'h07, 1'b0, 1'b0};
    vt[13] = '{8'h2F, 8'h00, 1'b1, 8'h09, 8'h07, 1'b0, 1'b1};

    // reset state
    cyc(2);
    chk("rst_hr", disp_hr, 8'h00);
    chk("rst_min", disp_min, 8'h00);
    chk("rst_sec", disp_sec, 8'h00);
    chk("rst_snd", {7'd0, alarm_sound}, 8'd0);
    chk("rst_err", {7'd0, set_err}, 8'd0);
    reset = 1'b1;
    cyc(1);

    // load/validate/12h table; valid loads fall on tick cycles
    foreach (vt[i]) begin
      mode_12h = vt[i].m12;
      set_t(vt[i].hr, vt[i].mn);
      chk($sformatf("v%0d_hr", i), disp_hr, vt[i].e_hr);
      chk($sformatf("v%0d_min", i), disp_min, vt[i].e_min);
      chk($sformatf("v%0d_sec", i), disp_sec, 8'h00);
      chk($sformatf("v%0d_pm", i), {7'd0, pm}, {7'd0, vt[i].e_pm});
      chk($sformatf("v%0d_err", i), {7'd0, set_err}, {7'd0, vt[i].e_err});
      cyc(1);
      chk($sformatf("v%0d_err0", i), {7'd0, set_err}, 8'd0);
    end
    mode_12h = 1'b0;

    // day rollover at normal rate
    set_t(8'h23, 8'h59);
    cyc(4);
    chk("t1_sec1", disp_sec, 8'h01);
    cyc(232);
    chk("t1_hr59", disp_hr, 8'h23);
    chk("t1_min59", disp_min, 8'h59);
    chk("t1_sec59", disp_sec, 8'h59);
    chk("t1_pm1", {7'd0, pm}, 8'd1);
    cyc(4);
    chk("t1_hr", disp_hr, 8'h00);
    chk("t1_min", disp_min, 8'h00);
    chk("t1_sec", disp_sec, 8'h00);
    chk("t1_pm0", {7'd0, pm}, 8'd0);
    chk("t1_snd", {7'd0, alarm_sound}, 8'd0);
    mode_12h = 1'b1;
    #1 chk("t1_12h", disp_hr, 8'h12);
    mode_12h = 1'b0;

    // two slots match, lowest enabled wins
    cyc(1);
    wr_alm(2'd0, 8'h07, 8'h00, 1'b0);
    wr_alm(2'd1, 8'h07, 8'h00, 1'b1);
    wr_alm(2'd2, 8'h07, 8'h00, 1'b1);
    wr_alm(2'd3, 8'h24, 8'h00, 1'b1);
    chk("t3_werr", {7'd0, set_err}, 8'd1);
    fastwatch = 1'b1;
    set_t(8'h06, 8'h59);
    cyc(3);
    chk("t3_snd0", {7'd0, alarm_sound}, 8'd0);
    chk("t3_min59", disp_min, 8'h59);
    cyc(1);
    chk("t3_snd", {7'd0, alarm_sound}, 8'd1);
    chk("t3_id", {6'd0, alarm_id}, 8'd1);
    chk("t3_hr", disp_hr, 8'h07);
    chk("t3_min", disp_min, 8'h00);
    chk("t3_sec", disp_sec, 8'h00);

    // snooze, re-ring, then stop beats snooze
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    chk("t4_snz", {7'd0, alarm_sound}, 8'd0);
    chk("t4_id", {6'd0, alarm_id}, 8'd1);
    cyc(18);
    chk("t4_pre", {7'd0, alarm_sound}, 8'd0);
    chk("t4_min4", disp_min, 8'h04);
    cyc(1);
    chk("t4_rering", {7'd0, alarm_sound}, 8'd1);
    chk("t4_min5", disp_min, 8'h05);
    stop   = 1'b1;
    snooze = 1'b1;
    cyc(1);
    stop   = 1'b0;
    snooze = 1'b0;
    chk("t4_stop", {7'd0, alarm_sound}, 8'd0);
    cyc(20);
    chk("t4_idle", {7'd0, alarm_sound}, 8'd0);

    // ring timeout, then disabled slots do not ring
    set_t(8'h06, 8'h59);
    cyc(4);
    chk("t5_ring", {7'd0, alarm_sound}, 8'd1);
    cyc(4);
    chk("t5_ring1", {7'd0, alarm_sound}, 8'd1);
    cyc(3);
    chk("t5_ring2", {7'd0, alarm_sound}, 8'd1);
    cyc(1);
    chk("t5_tmo", {7'd0, alarm_sound}, 8'd0);
    wr_alm(2'd1, 8'h07, 8'h00, 1'b0);
    wr_alm(2'd2, 8'h07, 8'h00, 1'b0);
    set_t(8'h06, 8'h59);
    cyc(4);
    chk("t5_dis_min", disp_min, 8'h00);
    chk("t5_dis", {7'd0, alarm_sound}, 8'd0);

    // async reset mid-ring
    wr_alm(2'd3, 8'h07, 8'h00, 1'b1);
    set_t(8'h06, 8'h59);
    cyc(4);
    chk("t6_ring", {7'd0, alarm_sound}, 8'd1);
    chk("t6_id", {6'd0, alarm_id}, 8'd3);
    wr_alm(2'd3, 8'h07, 8'h00, 1'b0);
    chk("t6_keep", {7'd0, alarm_sound}, 8'd1);
    wr_alm(2'd3, 8'h07, 8'h00, 1'b1);
    reset = 1'b0;
    #1 chk("t6_async", {7'd0, alarm_sound}, 8'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("t6_hr", disp_hr, 8'h00);
    chk("t6_min", disp_min, 8'h00);
    chk("t6_sec", disp_sec, 8'h00);
    chk("t6_id0", {6'd0, alarm_id}, 8'd0);
    set_t(8'h23, 8'h59);
    cyc(4);
    chk("t6_mid", disp_hr, 8'h00);
    chk("t6_nomatch0", {7'd0, alarm_sound}, 8'd0);
    set_t(8'h06, 8'h59);
    cyc(4);
    chk("t6_min7", disp_hr, 8'h07);
    chk("t6_nomatch7", {7'd0, alarm_sound}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
